// File: rtl/bit_manip_pkg.sv
// Shared definitions for the bit-manipulation dispatcher: op encodings,
// FSM state type, command record and the op legality helper.
package bit_manip_pkg;

    localparam logic [2:0] OP_CLR = 3'd0;
    localparam logic [2:0] OP_SET = 3'd1;
    localparam logic [2:0] OP_TST = 3'd2;
    localparam logic [2:0] OP_OP3 = 3'd3;

    localparam int BM_DATA_W = 64;
    localparam int BM_TAG_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } bm_state_e;

    typedef struct packed {
        logic [2:0]           op;
        logic [BM_DATA_W-1:0] opa;
        logic [BM_DATA_W-1:0] opb;
        logic [BM_TAG_W-1:0]  tag;
    } bm_cmd_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_OP3;
    endfunction

endpackage

// File: rtl/bit_manip_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module bit_manip_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/bit_manip_dispatch.sv
// Issue stage for int_bit_manip_16: queues commands, drives the unit one at a time,
// screens illegal ones. Define BIT_MANIP_DISPATCH_STATS_EN to add issued/error counters.
module bit_manip_dispatch
    import bit_manip_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 4,
    parameter int TAG_W    = 4,
    parameter int UNIT_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_opa,
    input  logic [DATA_W-1:0] cmd_opb,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [2:0]        operation,
    output logic [DATA_W-1:0] opa_bit_manip,
    output logic [DATA_W-1:0] opb_bit_manip,
    input  logic [DATA_W-1:0] out_bit_manip,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err
`ifdef BIT_MANIP_DISPATCH_STATS_EN
    ,
    output logic [31:0]       issued_cnt,
    output logic [31:0]       err_cnt
`endif
);
    localparam int IDX_W = $clog2(DATA_W);
    localparam int CNT_W = (UNIT_LAT > 1) ? $clog2(UNIT_LAT) : 1;

    typedef struct packed {
        logic [2:0]        op;
        logic [DATA_W-1:0] opa;
        logic [DATA_W-1:0] opb;
        logic [TAG_W-1:0]  tag;
    } cmd_t;

    cmd_t              cmd_in, head;
    logic              fifo_full, fifo_empty, pop, head_legal;
    bm_state_e         state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [2:0]        operation_q, operation_d;
    logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d, rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
    logic              rsp_err_q, rsp_err_d;

    assign cmd_in = '{op: cmd_op, opa: cmd_opa, opb: cmd_opb, tag: cmd_tag};

    bit_manip_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(cmd_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid && cmd_ready),
        .din   (cmd_in),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A bit index is legal only if it addresses a bit inside the operand.
    assign head_legal = op_is_legal(head.op) && (head.opb[DATA_W-1:IDX_W] == '0);

    assign cmd_ready     = !fifo_full;
    assign rsp_valid     = (state_q == RESP);
    assign operation     = operation_q;
    assign opa_bit_manip = opa_q;
    assign opb_bit_manip = opb_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_tag       = rsp_tag_q;
    assign rsp_err       = rsp_err_q;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        operation_d = operation_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_err_d   = rsp_err_q;
        pop         = 1'b0;

        case (state_q)
            IDLE:  pop = !fifo_empty;
            ISSUE: begin
                state_d    = WAIT;
                wait_cnt_d = CNT_W'(UNIT_LAT - 1);
            end
            WAIT: begin
                if (wait_cnt_q == '0) begin
                    rsp_data_d = out_bit_manip;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    if (fifo_empty) state_d = IDLE;
                    else            pop     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Illegal commands bypass the unit entirely so its inputs keep their last values.
        if (pop) begin
            rsp_tag_d = head.tag;
            if (head_legal) begin
                operation_d = head.op;
                opa_d       = head.opa;
                opb_d       = head.opb;
                state_d     = ISSUE;
            end else begin
                rsp_data_d = '0;
                rsp_err_d  = 1'b1;
                state_d    = RESP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            operation_q <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            operation_q <= operation_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef BIT_MANIP_DISPATCH_STATS_EN
    logic [31:0] issued_cnt_q, issued_cnt_d, err_cnt_q, err_cnt_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_comb begin
        issued_cnt_d = issued_cnt_q;
        err_cnt_d    = err_cnt_q;
        if (pop && head_legal)  issued_cnt_d = sat_inc(issued_cnt_q);
        if (pop && !head_legal) err_cnt_d    = sat_inc(err_cnt_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_cnt_q <= '0;
            err_cnt_q    <= '0;
        end else begin
            issued_cnt_q <= issued_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign issued_cnt = issued_cnt_q;
    assign err_cnt    = err_cnt_q;
`endif

endmodule

// File: tb/tb_bit_manip_dispatch.sv
// Self-checking bench for bit_manip_dispatch with a behavioural single-cycle
// bit-manipulation unit standing in for int_bit_manip_16.
module tb_bit_manip_dispatch;
    localparam int DW    = 64;
    localparam int TW    = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready;
    logic [2:0]    cmd_op;
    logic [DW-1:0] cmd_opa, cmd_opb;
    logic [TW-1:0] cmd_tag;
    logic [2:0]    operation;
    logic [DW-1:0] opa_bit_manip, opb_bit_manip, out_bit_manip;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [TW-1:0] rsp_tag;
    logic          rsp_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    bit_manip_dispatch #(.DATA_W(DW), .DEPTH(DEPTH), .TAG_W(TW), .UNIT_LAT(1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_opa       (cmd_opa),
        .cmd_opb       (cmd_opb),
        .cmd_tag       (cmd_tag),
        .operation     (operation),
        .opa_bit_manip (opa_bit_manip),
        .opb_bit_manip (opb_bit_manip),
        .out_bit_manip (out_bit_manip),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_tag       (rsp_tag),
        .rsp_err       (rsp_err)
    );

    // Unit stand-in: one clock edge of latency, op 3 toggles the addressed bit.
    function automatic logic [DW-1:0] unit_fn(input logic [2:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        logic [DW-1:0] r;
        int idx;
        idx = int'(b[5:0]);
        r = a;
        case (op)
            3'd0: r[idx] = 1'b0;
            3'd1: r[idx] = 1'b1;
            3'd2: begin r = '0; r[0] = a[idx]; end
            3'd3: r[idx] = ~a[idx];
            default: r = '0;
        endcase
        return r;
    endfunction

    always @(posedge clk) out_bit_manip <= unit_fn(operation, opa_bit_manip, opb_bit_manip);

    function automatic exp_t ref_model(input logic [2:0] op, input logic [DW-1:0] a,
                                       input logic [DW-1:0] b, input logic [TW-1:0] tag);
        exp_t e;
        logic [DW-1:0] m;
        e.tag = tag;
        e.err = 1'b0;
        m = 64'd1 << b;
        if (op > 3 || b >= 64) begin
            e.err  = 1'b1;
            e.data = '0;
        end else if (op == 0) e.data = a & ~m;
        else if (op == 1)     e.data = a | m;
        else if (op == 2)     e.data = ((a & m) != 0) ? 64'd1 : 64'd0;
        else                  e.data = a ^ m;
        return e;
    endfunction

    task automatic push_cmd(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [TW-1:0] tag, output int waited);
        bit rdy;
        waited = 0;
        cmd_op = op; cmd_opa = a; cmd_opb = b; cmd_tag = tag; cmd_valid = 1'b1;
        do begin
            @(negedge clk);
            rdy = cmd_ready;
            @(posedge clk);
            waited++;
        end while (!rdy && waited < 100);
        if (rdy) exp_q.push_back(ref_model(op, a, b, tag));
        else begin
            checks++; errors++;
            $display("FAIL push_timeout tag=%0d: cmd_ready never seen, required within 100 cycles", tag);
        end
        #1 cmd_valid = 1'b0;
    endtask

    task automatic collect(input int n, input bit toggle, input int limit);
        int got = 0;
        int cyc = 0;
        exp_t e;
        while (got < n && cyc < limit) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_extra: got tag=%0d data=%h, required no response", rsp_tag, rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_tag !== e.tag || rsp_data !== e.data || rsp_err !== e.err) begin
                        errors++;
                        $display("FAIL rsp_order: got tag=%0d data=%h err=%b, required tag=%0d data=%h err=%b",
                                 rsp_tag, rsp_data, rsp_err, e.tag, e.data, e.err);
                    end
                end
                got++;
            end
            @(posedge clk);
            #1;
            if (toggle) rsp_ready = ~rsp_ready;
            cyc++;
        end
        checks++;
        if (got != n || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rsp_count: got %0d responses (%0d left pending), required %0d", got, exp_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_opa = '0; cmd_opb = '0; cmd_tag = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_err, rsp_data, rsp_tag, operation, opa_bit_manip, opb_bit_manip} !== '0
            || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: rsp_valid=%b rsp_err=%b op=%0d cmd_ready=%b, required all 0 and cmd_ready=1",
                     rsp_valid, rsp_err, operation, cmd_ready);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic single_case(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input logic [TW-1:0] tag, input logic [DW-1:0] data, input logic err,
                               input int lat_req);
        int w, lat;
        logic [2:0] u_op;
        logic [DW-1:0] u_a, u_b;
        u_op = operation; u_a = opa_bit_manip; u_b = opb_bit_manip;
        rsp_ready = 1'b0;
        push_cmd(op, a, b, tag, w);
        lat = 0;
        @(negedge clk);
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != lat_req) begin
            errors++;
            $display("FAIL latency tag=%0d: rsp_valid after %0d edges, required %0d", tag, lat, lat_req);
        end
        checks++;
        if (rsp_data !== data || rsp_tag !== tag || rsp_err !== err) begin
            errors++;
            $display("FAIL single_rsp tag=%0d: data=%h tag=%0d err=%b, required data=%h tag=%0d err=%b",
                     tag, rsp_data, rsp_tag, rsp_err, data, tag, err);
        end
        if (err) begin
            checks++;
            if (operation !== u_op || opa_bit_manip !== u_a || opb_bit_manip !== u_b) begin
                errors++;
                $display("FAIL unit_hold tag=%0d: op=%0d opa=%h opb=%h, required op=%0d opa=%h opb=%h",
                         tag, operation, opa_bit_manip, opb_bit_manip, u_op, u_a, u_b);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_legal();
        single_case(3'd1, 64'd0,  64'd2, 4'd5, 64'd4,  1'b0, 3);
        single_case(3'd0, 64'd18, 64'd4, 4'd6, 64'd2,  1'b0, 3);
        single_case(3'd1, 64'd2,  64'd5, 4'd7, 64'd34, 1'b0, 3);
        single_case(3'd2, 64'd18, 64'd1, 4'd8, 64'd1,  1'b0, 3);
        single_case(3'd2, 64'd18, 64'd2, 4'd9, 64'd0,  1'b0, 3);
    endtask

    task automatic test_illegal();
        single_case(3'd5, {$urandom, $urandom}, 64'd3,  4'd10, 64'd0, 1'b1, 1);
        single_case(3'd1, {$urandom, $urandom}, 64'd64, 4'd11, 64'd0, 1'b1, 1);
    endtask

    task automatic test_fill_backpressure();
        int w, total;
        logic [DW-1:0] a[6];
        total = 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) a[i] = {$urandom, $urandom};
        for (int i = 0; i < DEPTH + 1; i++) begin
            push_cmd(3'(i % 4), a[i], 64'(i * 7), 4'(i), w);
            total += w;
        end
        checks++;
        if (total != DEPTH + 1) begin
            errors++;
            $display("FAIL fill_accept: %0d cycles for %0d pushes, required %0d", total, DEPTH + 1, DEPTH + 1);
        end
        cmd_op = 3'd1; cmd_opa = a[5]; cmd_opb = 64'd63; cmd_tag = 4'd5; cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL fill_full cycle %0d: cmd_ready=%b, required 0", k, cmd_ready);
            end
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        fork
            push_cmd(3'd1, a[5], 64'd63, 4'd5, w);
            collect(6, 1'b0, 100);
        join
        rsp_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int n;
        n = 3 * DEPTH;
        rsp_ready = 1'b1;
        fork
            begin
                int w;
                logic [2:0] op;
                logic [DW-1:0] b;
                for (int i = 0; i < n; i++) begin
                    op = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
                    b  = ($urandom_range(0, 7) == 0) ? 64'($urandom_range(64, 5000)) : 64'($urandom_range(0, 63));
                    push_cmd(op, {$urandom, $urandom}, b, 4'(i), w);
                end
            end
            collect(n, 1'b1, 600);
        join
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        int w;
        bit saw;
        rsp_ready = 1'b0;
        push_cmd(3'd1, 64'h55, 64'd9,  4'd1, w);
        push_cmd(3'd0, 64'hFF, 64'd0,  4'd2, w);
        push_cmd(3'd3, 64'h0F, 64'd31, 4'd3, w);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_err, rsp_data, rsp_tag, operation, opa_bit_manip, opb_bit_manip} !== '0
            || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_state: rsp_valid=%b op=%0d opa=%h cmd_ready=%b, required all 0 and cmd_ready=1",
                     rsp_valid, operation, opa_bit_manip, cmd_ready);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) saw = 1'b1;
        end
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL midreset_flush: rsp_valid seen=%b after reset, required 0", saw);
        end
        @(posedge clk);
        #1;
        fork
            push_cmd(3'd1, 64'd2, 64'd5, 4'd12, w);
            collect(1, 1'b0, 30);
        join
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_legal();
        test_illegal();
        test_fill_backpressure();
        test_wrap();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bit_manip_dispatch.md
Name: bit_manip_dispatch

Overview:
- Upstream issue stage for the int_bit_manip_16 unit.
- Buffers bit-manipulation commands (op, opa, opb, tag) in a small FIFO.
- Drives the unit's operation/opa_bit_manip/opb_bit_manip inputs one command at a time, waits the unit's fixed latency, then returns the captured out_bit_manip with its tag over a valid/ready response port.
- Screens illegal commands so they never reach the unit.

Parameters:
- DATA_W, 64, operand/result width; equals unit width.
- DEPTH, 4, command FIFO entries; power of two, ≥2.
- TAG_W, 4, width of the command tag returned with each response.
- UNIT_LAT, 1, unit latency in clock edges from inputs presented to result valid; ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_op  in  3  0=clear bit, 1=set bit, 2=test bit, 3=unit op 3, 4..7 illegal.
- cmd_opa  in  DATA_W  operand A.
- cmd_opb  in  DATA_W  bit index.
- cmd_tag  in  TAG_W  caller tag.
- operation  out  3  to unit.
- opa_bit_manip  out  DATA_W  to unit.
- opb_bit_manip  out  DATA_W  to unit.
- out_bit_manip  in  DATA_W  result from unit.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts.
- rsp_data  out  DATA_W  captured result; 0 on error.
- rsp_tag  out  TAG_W  tag of the responding command.
- rsp_err  out  1  command was illegal.

Behaviour:
- Reset (async, rst_n=0): all of the following cleared, and any in-flight command is discarded with no response:
  - FIFO pointers and count to 0; cmd_ready=1.
  - state=IDLE.
  - operation, opa_bit_manip, opb_bit_manip, rsp_data, rsp_tag all 0; rsp_valid=0; rsp_err=0.
- Push: occurs on cmd_valid&&cmd_ready. cmd_ready is derived from the registered count, so a push while full is refused even if a pop happens in the same cycle. A simultaneous push and pop at a non-full, non-empty FIFO leaves the count unchanged. Pointers wrap modulo DEPTH.
- Legality check: a command is illegal if cmd_op>3, or if cmd_opb ≥ DATA_W (any bit above log2(DATA_W)-1 set). The check is evaluated at pop.
- FSM:
  - IDLE: if FIFO is non-empty, pop the head.
    - Legal command: load the unit input registers, go to ISSUE.
    - Illegal command: rsp_data=0, rsp_err=1, go to RESP.
  - ISSUE: exactly 1 cycle; unit inputs are stable. Go to WAIT and load the wait counter with UNIT_LAT-1.
  - WAIT: decrement the counter. When it reaches 0, capture out_bit_manip into rsp_data, set rsp_err=0, go to RESP.
  - RESP: rsp_valid=1 and rsp_data/rsp_tag/rsp_err are held stable until rsp_ready.
    - On handshake with FIFO non-empty: pop the next command directly (ISSUE or RESP as in IDLE).
    - On handshake with FIFO empty: go to IDLE, rsp_valid=0.
- Unit inputs hold their last issued values outside ISSUE/WAIT and are never changed during ISSUE/WAIT.
- Latency (no backpressure, empty FIFO):
  - Legal command: rsp_valid rises after clock edge 2+UNIT_LAT counted from the accepting edge (edge 3 for UNIT_LAT=1).
  - Illegal command: rsp_valid rises after edge 1.
- Throughput: one command per 2+UNIT_LAT cycles under continuous rsp_ready=1.
- Responses are returned in command order.

Optional Feature:
- Macro: BIT_MANIP_DISPATCH_STATS_EN.
- Defined: adds output ports issued_cnt[31:0] and err_cnt[31:0].
  - issued_cnt increments on every entry to ISSUE; err_cnt increments on every illegal pop.
  - Both are reset to 0 and saturate at all-ones.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package bit_manip_pkg holds:
  - Op encodings OP_CLR=0, OP_SET=1, OP_TST=2, OP_OP3=3.
  - Typedef for the FSM state enum {IDLE, ISSUE, WAIT, RESP}.
  - Typedef for the command struct {op, opa, opb, tag}.
- One sub-module: bit_manip_cmd_fifo, a parameterized synchronous FIFO (DEPTH, entry width) with full/empty/count.

Test Plan:
- Bench: the dispatcher instantiated with int_bit_manip_16 behind it.
- Single legal commands, each -> rsp_data as listed, rsp_err=0, rsp_valid 3 edges after accept:
  - op=1 opa=0 opb=2 tag=5 -> rsp_data=4, rsp_tag=5.
  - op=0 opa=18 opb=4 -> 2.
  - op=1 opa=2 opb=5 -> 34.
  - op=2 opa=18 opb=1 -> 1.
  - op=2 opa=18 opb=2 -> 0.
- Illegal commands:
  - op=5 -> rsp_err=1, rsp_data=0, rsp_valid 1 edge after accept, unit inputs unchanged.
  - op=1 opb=64 -> same error response.
- Fill and backpressure: hold rsp_ready=0 and push DEPTH+2 commands (tags 0..5).
  - Required: cmd_ready drops after DEPTH+1 accepts (DEPTH in the FIFO, 1 in RESP).
  - Then release rsp_ready: tags return 0..5 in order, data correct.
- Pointer wrap: stream 3×DEPTH commands with rsp_ready toggling every cycle -> no loss, no duplication, order preserved.
- Reset mid-operation: assert rst_n=0 during WAIT with 2 commands queued.
  - Required: all outputs 0 and cmd_ready=1 immediately.
  - No response ever appears for the flushed commands.
  - A subsequent command completes normally.
